// File: rtl/mips32_mem_pkg.sv
// Shared types and constants for the MIPS32 memory responder.
//   state_e      : responder FSM states (idle / wait / response)
//   DataWDefault : default word width
//   MaxLatency   : largest supported access latency (4-bit wait counter)
package mips32_mem_pkg;

  localparam int unsigned DataWDefault = 32;
  localparam int unsigned MaxLatency   = 15;
  localparam int unsigned CntW         = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/mips32_mem_responder_if.sv
// Request/response channel between the MIPS32 core (master) and the memory responder (slave).
//   req_valid/req_ready : request handshake; req_we selects store, req_addr is a word address
//   req_wdata           : store data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data (0 for stores and errors)
//   rsp_err             : address out of range
interface mips32_mem_responder_if #(
  parameter int unsigned DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/mips32_mem_array.sv
// Single-port DEPTH x DATA_W word storage. Synchronous write, registered read with enable.
// Contents and read register are not reset.
//   clk_i   : clock
//   addr_i  : word address
//   we_i    : write enable (wdata_i stored at addr_i)
//   re_i    : read enable (rdata_o updated from addr_i, otherwise held)
//   wdata_i : write data
//   rdata_o : registered read data
module mips32_mem_array #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic [AddrW-1:0]  addr_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory-side responder for MIPS32 fetch/LW/SW traffic. One outstanding transaction, programmable
// access latency: a request accepted on edge N produces rsp_valid after edge N+1+LATENCY.
//   clk   : clock
//   rst_n : asynchronous active-low reset (array contents are kept)
//   bus   : slave side of the request/response channel
module mips32_mem_responder
  import mips32_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned DATA_W  = DataWDefault,
  parameter int unsigned LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  mips32_mem_responder_if.slave   bus
);

  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CntW-1:0] LatCnt = CntW'(LATENCY);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q, err_d;
  logic              cap_en;
  logic              access;
  logic              in_range;
  logic [DATA_W-1:0] arr_rdata;

  // Full 32-bit unsigned compare so large addresses never alias into the array.
  assign in_range = (addr_q < 32'(DEPTH));

  // The wait phase lasts LATENCY+1 cycles; its final cycle presents the array access so that the
  // write commits, or the registered read lands, on the edge that enters the response phase.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    cap_en  = 1'b0;
    access  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          cap_en  = 1'b1;
          cnt_d   = LatCnt;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          access  = 1'b1;
          err_d   = ~in_range;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (bus.rsp_ready) begin
          err_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (cap_en) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  mips32_mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk_i   (clk),
    .addr_i  (addr_q[AddrW-1:0]),
    .we_i    (access & in_range & we_q),
    .re_i    (access & in_range & ~we_q),
    .wdata_i (wdata_q),
    .rdata_o (arr_rdata)
  );

  // The array read register only updates on response entry, so it stays stable through
  // backpressure; stores, errors and idle cycles are masked to zero.
  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_err   = err_q;
  assign bus.rsp_rdata = ((state_q == StResp) && !we_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_mips32_mem_responder.sv
module tb_mips32_mem_responder;

  localparam int unsigned Depth = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_v     [2];
  logic        req_valid_v [2];
  logic        req_we_v    [2];
  logic [31:0] req_addr_v  [2];
  logic [31:0] req_wdata_v [2];
  logic        rsp_ready_v [2];

  int lat_v [2] = '{2, 0};
  int n_checks = 0;
  int n_fail   = 0;

  // Reference memory, keyed by {dut index, word address}; only written words are known.
  logic [31:0] model [bit [63:0]];

  mips32_mem_responder_if #(.DATA_W(32)) bus_a ();
  mips32_mem_responder_if #(.DATA_W(32)) bus_b ();

  assign bus_a.req_valid = req_valid_v[0];
  assign bus_a.req_we    = req_we_v[0];
  assign bus_a.req_addr  = req_addr_v[0];
  assign bus_a.req_wdata = req_wdata_v[0];
  assign bus_a.rsp_ready = rsp_ready_v[0];
  assign bus_b.req_valid = req_valid_v[1];
  assign bus_b.req_we    = req_we_v[1];
  assign bus_b.req_addr  = req_addr_v[1];
  assign bus_b.req_wdata = req_wdata_v[1];
  assign bus_b.rsp_ready = rsp_ready_v[1];

  mips32_mem_responder #(.DEPTH(Depth), .DATA_W(32), .LATENCY(2)) dut_a (
    .clk   (clk),
    .rst_n (rst_n_v[0]),
    .bus   (bus_a.slave)
  );

  mips32_mem_responder #(.DEPTH(Depth), .DATA_W(32), .LATENCY(0)) dut_b (
    .clk   (clk),
    .rst_n (rst_n_v[1]),
    .bus   (bus_b.slave)
  );

  function automatic logic get_ready(int k);
    return (k != 0) ? bus_b.req_ready : bus_a.req_ready;
  endfunction

  function automatic logic get_valid(int k);
    return (k != 0) ? bus_b.rsp_valid : bus_a.rsp_valid;
  endfunction

  function automatic logic get_err(int k);
    return (k != 0) ? bus_b.rsp_err : bus_a.rsp_err;
  endfunction

  function automatic logic [31:0] get_rdata(int k);
    return (k != 0) ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  endfunction

  function automatic bit [63:0] mkey(int k, logic [31:0] a);
    return {32'(k), a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction: accept, latency count, optional backpressure, response handshake.
  task automatic run_txn(input int k, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input bit junk,
                         input bit early);
    bit          exp_err;
    bit          known;
    logic [31:0] exp_rdata;
    int          cnt;
    int          h;

    exp_err   = (addr >= 32'(Depth));
    known     = 1'b1;
    exp_rdata = 32'h0;
    if (!we && !exp_err) begin
      if (model.exists(mkey(k, addr))) exp_rdata = model[mkey(k, addr)];
      else known = 1'b0;
    end

    check_eq("idle_ready", 32'(get_ready(k)), 32'd1);
    req_valid_v[k] = 1'b1;
    req_we_v[k]    = we;
    req_addr_v[k]  = addr;
    req_wdata_v[k] = wdata;
    rsp_ready_v[k] = early;
    @(posedge clk);
    #1;
    req_valid_v[k] = 1'b0;
    if (we && !exp_err) model[mkey(k, addr)] = wdata;
    if (junk) begin
      // Must be ignored: the responder is busy until the response handshake.
      req_valid_v[k] = 1'b1;
      req_we_v[k]    = 1'b0;
      req_addr_v[k]  = $urandom_range(15, 0);
    end

    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (!get_valid(k) && cnt < 40);
    check_eq("latency", 32'(cnt), 32'(lat_v[k] + 1));
    check_eq("resp_ready_low", 32'(get_ready(k)), 32'd0);
    check_eq("rsp_err", 32'(get_err(k)), 32'(exp_err));
    if (known) check_eq("rsp_rdata", get_rdata(k), exp_rdata);

    if (!early) begin
      for (h = 0; h < hold; h++) begin
        @(posedge clk);
        #1;
        check_eq("hold_valid", 32'(get_valid(k)), 32'd1);
        check_eq("hold_err", 32'(get_err(k)), 32'(exp_err));
        if (known) check_eq("hold_rdata", get_rdata(k), exp_rdata);
      end
      rsp_ready_v[k] = 1'b1;
    end
    @(posedge clk);
    #1;
    rsp_ready_v[k] = 1'b0;
    req_valid_v[k] = 1'b0;
    check_eq("post_valid", 32'(get_valid(k)), 32'd0);
    check_eq("post_err", 32'(get_err(k)), 32'd0);
    check_eq("post_ready", 32'(get_ready(k)), 32'd1);
    check_eq("post_rdata", get_rdata(k), 32'd0);
  endtask

  initial begin
    logic [31:0] addr;
    int          k;
    int          r;

    for (int i = 0; i < 2; i++) begin
      rst_n_v[i]     = 1'b0;
      req_valid_v[i] = 1'b0;
      req_we_v[i]    = 1'b0;
      req_addr_v[i]  = '0;
      req_wdata_v[i] = '0;
      rsp_ready_v[i] = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq("rst_ready", 32'(get_ready(i)), 32'd1);
      check_eq("rst_valid", 32'(get_valid(i)), 32'd0);
      check_eq("rst_err", 32'(get_err(i)), 32'd0);
      check_eq("rst_rdata", get_rdata(i), 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n_v[0] = 1'b1;
    rst_n_v[1] = 1'b1;
    @(posedge clk);
    #1;

    // Store then load at LATENCY=2.
    run_txn(0, 1'b1, 32'd5, 32'hDEADBEEF, 0, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'd5, 32'h0, 0, 1'b0, 1'b0);
    // LATENCY=0 load of address 0 (after a store so the value is known).
    run_txn(1, 1'b1, 32'd0, 32'h0BADF00D, 0, 1'b0, 1'b0);
    run_txn(1, 1'b0, 32'd0, 32'h0, 0, 1'b0, 1'b0);
    // Backpressure for 5 cycles with an ignored request pending.
    run_txn(0, 1'b0, 32'd5, 32'h0, 5, 1'b1, 1'b0);
    // Out-of-range store must not touch the array.
    run_txn(0, 1'b1, 32'd0, 32'h12345678, 0, 1'b0, 1'b0);
    run_txn(0, 1'b1, 32'(Depth), 32'd7, 0, 1'b0, 1'b0);
    run_txn(0, 1'b0, 32'd0, 32'h0, 0, 1'b0, 1'b0);
    run_txn(0, 1'b1, 32'hFFFF_FC00, 32'd9, 1, 1'b0, 1'b0);

    // Reset during WAIT drops a pending store.
    run_txn(0, 1'b1, 32'd9, 32'h1111_2222, 0, 1'b0, 1'b0);
    req_valid_v[0] = 1'b1;
    req_we_v[0]    = 1'b1;
    req_addr_v[0]  = 32'd9;
    req_wdata_v[0] = 32'd3;
    @(posedge clk);
    #1;
    req_valid_v[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n_v[0] = 1'b0;
    #1;
    check_eq("midrst_ready", 32'(get_ready(0)), 32'd1);
    check_eq("midrst_valid", 32'(get_valid(0)), 32'd0);
    check_eq("midrst_err", 32'(get_err(0)), 32'd0);
    @(negedge clk);
    rst_n_v[0] = 1'b1;
    @(posedge clk);
    #1;
    run_txn(0, 1'b0, 32'd9, 32'h0, 0, 1'b0, 1'b0);

    // Randomized traffic on both instances.
    for (int i = 0; i < 120; i++) begin
      k = $urandom_range(1, 0);
      r = $urandom_range(9, 0);
      if (r < 6)       addr = $urandom_range(15, 0);
      else if (r == 6) addr = Depth - 1;
      else if (r == 7) addr = Depth;
      else if (r == 8) addr = $urandom;
      else             addr = Depth + $urandom_range(7, 0);
      run_txn(k, 1'($urandom_range(1, 0)), addr, $urandom, $urandom_range(3, 0),
              1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
